// File: rtl/phy_rx_lane_ctrl.sv
// phy_rx_lane_ctrl: two-lane PCIe PHY RX link controller on clk_32f.
//
// Locks onto the link by counting consecutive COM symbols on both lanes,
// then un-stripes lane byte pairs into 32-bit words. A run of misaligned
// pairs (exactly one lane carrying COM) drops the link back to search.
//
// Ports:
//   clk_32f     in   1  clock, rising edge
//   reset       in   1  asynchronous, active-low clear
//   byte_in_0   in   8  lane 0 byte, sampled when byte_valid=1
//   byte_in_1   in   8  lane 1 byte, sampled when byte_valid=1
//   byte_valid  in   1  one-cycle strobe per byte time
//   link_up     out  1  high while locked
//   data_out    out 32  last assembled word {lane0_hi, lane1_hi, lane0_lo, lane1_lo}
//   valid_out   out  1  one-cycle pulse per assembled word
//   err_total   out  8  saturating count of misaligned pairs seen while locked
//
// Build option: define PHY_RX_CTRL_STATS_EN to implement err_total;
// otherwise err_total is tied to 8'h00.

module phy_rx_lane_ctrl #(
  parameter logic [7:0]  COM_SYMBOL = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERR_LIMIT  = 2
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic [7:0]  byte_in_0,
  input  logic [7:0]  byte_in_1,
  input  logic        byte_valid,
  output logic        link_up,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic [7:0]  err_total
);

  localparam logic [2:0] LockCnt = 3'(LOCK_COUNT);
  localparam logic [2:0] ErrLim  = 3'(ERR_LIMIT);

  typedef enum logic [0:0] {StSearch, StLocked} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_0_q, cnt_0_d;
  logic [2:0]  cnt_1_q, cnt_1_d;
  logic        half_q, half_d;
  logic [7:0]  hi_0_q, hi_0_d;
  logic [7:0]  hi_1_q, hi_1_d;
  logic [2:0]  err_run_q, err_run_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;

  logic is_com_0, is_com_1;

  assign is_com_0 = (byte_in_0 == COM_SYMBOL);
  assign is_com_1 = (byte_in_1 == COM_SYMBOL);

  always_comb begin
    state_d   = state_q;
    cnt_0_d   = cnt_0_q;
    cnt_1_d   = cnt_1_q;
    half_d    = half_q;
    hi_0_d    = hi_0_q;
    hi_1_d    = hi_1_q;
    err_run_d = err_run_q;
    data_d    = data_q;
    valid_d   = 1'b0;

    if (byte_valid) begin
      unique case (state_q)
        StSearch: begin
          if (is_com_0) begin
            cnt_0_d = (cnt_0_q == LockCnt) ? LockCnt : cnt_0_q + 3'd1;
          end else begin
            cnt_0_d = 3'd0;
          end
          if (is_com_1) begin
            cnt_1_d = (cnt_1_q == LockCnt) ? LockCnt : cnt_1_q + 3'd1;
          end else begin
            cnt_1_d = 3'd0;
          end
          // The locking pair itself is alignment, never data.
          if (cnt_0_d == LockCnt && cnt_1_d == LockCnt) begin
            state_d = StLocked;
          end
        end
        StLocked: begin
          if (is_com_0 && is_com_1) begin
            // Idle pair: a pending half word cannot be completed across it.
            half_d    = 1'b0;
            err_run_d = 3'd0;
          end else if (!is_com_0 && !is_com_1) begin
            err_run_d = 3'd0;
            if (!half_q) begin
              hi_0_d = byte_in_0;
              hi_1_d = byte_in_1;
              half_d = 1'b1;
            end else begin
              data_d  = {hi_0_q, hi_1_q, byte_in_0, byte_in_1};
              valid_d = 1'b1;
              half_d  = 1'b0;
            end
          end else begin
            err_run_d = err_run_q + 3'd1;
            half_d    = 1'b0;
            if (err_run_d == ErrLim) begin
              state_d   = StSearch;
              cnt_0_d   = 3'd0;
              cnt_1_d   = 3'd0;
              err_run_d = 3'd0;
            end
          end
        end
        default: state_d = StSearch;
      endcase
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state_q   <= StSearch;
      cnt_0_q   <= 3'd0;
      cnt_1_q   <= 3'd0;
      half_q    <= 1'b0;
      hi_0_q    <= 8'h00;
      hi_1_q    <= 8'h00;
      err_run_q <= 3'd0;
      data_q    <= 32'h0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_0_q   <= cnt_0_d;
      cnt_1_q   <= cnt_1_d;
      half_q    <= half_d;
      hi_0_q    <= hi_0_d;
      hi_1_q    <= hi_1_d;
      err_run_q <= err_run_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
    end
  end

`ifdef PHY_RX_CTRL_STATS_EN
  logic [7:0] err_total_q;
  logic       err_pair;

  // Only misaligned pairs seen while locked are counted.
  assign err_pair = byte_valid && (state_q == StLocked) && (is_com_0 ^ is_com_1);

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      err_total_q <= 8'h00;
    end else if (err_pair && err_total_q != 8'hFF) begin
      err_total_q <= err_total_q + 8'd1;
    end
  end

  assign err_total = err_total_q;
`else
  assign err_total = 8'h00;
`endif

  assign link_up   = (state_q == StLocked);
  assign data_out  = data_q;
  assign valid_out = valid_q;

endmodule

// File: doc/phy_rx_lane_ctrl.md
# phy_rx_lane_ctrl

Two-lane receive link controller for the PCIe PHY RX path, clocked on `clk_32f`. It takes the per-lane parallel bytes produced after serial-to-parallel conversion of `data_in_0`/`data_in_1`. It achieves symbol lock by counting COM symbols on both lanes, then un-stripes the lane bytes into 32-bit words (`data_out`/`valid_out`). It also drops back to search when the lanes lose alignment.

## Interface
- `COM_SYMBOL`, 8'hBC: idle/alignment symbol.
- `LOCK_COUNT`, 4: consecutive COM pairs per lane needed for lock (1..7).
- `ERR_LIMIT`, 2: consecutive misaligned pairs that force relock (1..7).

Ports:
- `clk_32f`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state immediately.
- `byte_in_0`  in  8  lane 0 byte, sampled only when `byte_valid`=1.
- `byte_in_1`  in  8  lane 1 byte, sampled only when `byte_valid`=1.
- `byte_valid`  in  1  one-cycle strobe, one per byte time; arbitrary gaps allowed.
- `link_up`  out  1  1 while in LOCKED.
- `data_out`  out  32  assembled word; holds last value between pulses.
- `valid_out`  out  1  one-cycle pulse per assembled word.
- `err_total`  out  8  total misaligned pairs (see Configuration).

## Operation
- Pair: the (`byte_in_0`, `byte_in_1`) values on a strobe. Every pair falls into one of three classes:
  - COM pair: both bytes equal `COM_SYMBOL`.
  - data pair: neither byte equals `COM_SYMBOL`.
  - error pair: exactly one byte equals `COM_SYMBOL`.
- Per-lane 3-bit COM counters `cnt_0`/`cnt_1`, updated only in SEARCH and only on a strobe:
  - lane byte == COM: counter increments, saturating at `LOCK_COUNT`.
  - otherwise: counter clears to 0.
- States: SEARCH (after reset) and LOCKED.
- SEARCH -> LOCKED: on the strobe where both counters reach `LOCK_COUNT`. The pair on that strobe is consumed as alignment, not data.
- SEARCH: no assembly; `valid_out` stays 0.
- LOCKED, on each strobe:
  - COM pair: idle; clears the error run; discards any half word (half flag cleared).
  - data pair, half flag = 0: stores the pair as the upper half; sets the half flag; clears the error run.
  - data pair, half flag = 1: loads `data_out` = {stored lane0, stored lane1, `byte_in_0`, `byte_in_1`}; pulses `valid_out`; clears the half flag and the error run.
  - error pair: increments the error run and `err_total`; discards any half word.
  - error run == `ERR_LIMIT`: return to SEARCH; counters, half flag and error run cleared.
- `link_up` = (state == LOCKED).
- Width rules: the error run is 3 bits; `err_total` saturates at 8'hFF.
- Strobe absent: nothing changes.
- Reset values: `link_up`=0, `data_out`=0, `valid_out`=0, `err_total`=0, state SEARCH, all counters and flags 0.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- `valid_out`/`data_out` update on the clock edge that samples the second-half strobe (latency 1 cycle from strobe).
- `link_up` rises on the edge sampling the `LOCK_COUNT`-th consecutive COM pair.
- `link_up` falls on the edge sampling the `ERR_LIMIT`-th consecutive error pair.
- Back-to-back strobes (every cycle) must be supported at full rate.
- Reset mid-word or mid-lock: asynchronous clear; any partial word is lost. The first strobe after deassertion is treated as a SEARCH pair.

## Configuration
- `PHY_RX_CTRL_STATS_EN` defined: the `err_total` counter is implemented as described.
- Undefined: counter logic omitted and `err_total` is tied to 8'h00. All other behaviour is identical.

## Test plan
- Lock: 4 strobes of (BC,BC) -> `link_up`=1 after the 4th strobe edge. Separately, 3×(BC,BC) then (BC,00) -> `link_up` stays 0 and the lane 1 counter resets.
- Assembly: lock, then (11,22),(33,44) -> one `valid_out` pulse with `data_out`=32'h11223344, one cycle after the 2nd strobe.
- Idle mid-word: lock, then (11,22),(BC,BC),(33,44),(55,66) -> single word 32'h33445566; no word containing 11/22.
- Misalignment: lock, then (BC,00),(BC,00) -> `link_up`=0 after the 2nd strobe; `err_total`=2 (0 without macro). Then 4×(BC,BC) relocks.
- Error recovery: lock, then (BC,00),(AA,BB),(BC,00) -> `link_up` stays 1 (run cleared by the data pair); `err_total`=2.
- Reset: assert `reset`=0 after (11,22) in LOCKED, between clock edges -> all outputs 0 immediately. After release, (33,44),(55,66) produce no `valid_out`.
